// File: rtl/pal_line_sequencer.sv
// PAL 576i line sequencer: tracks frame line and horizontal position from regenerated
// sync, qualifies the field sequence with a lock FSM and schedules per-line events.
module pal_line_sequencer #(
   parameter int unsigned LINE_ODD     = 1,
   parameter int unsigned LINE_EVEN    = 313,
   parameter int unsigned LOCK_FIELDS  = 4,
   parameter int unsigned MISS_LIMIT   = 2,
   parameter int unsigned LINE_TIMEOUT = 5600,
   parameter int unsigned H_ACT_START  = 851,
   parameter int unsigned H_ACT_END    = 5063,
   parameter int unsigned V_ACT1_FIRST = 23,
   parameter int unsigned V_ACT1_LAST  = 310,
   parameter int unsigned V_ACT2_FIRST = 336,
   parameter int unsigned V_ACT2_LAST  = 623
) (
   input  logic        clk,
   input  logic        nReset,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        isFieldOdd,
   output logic [9:0]  lineNumber,
   output logic [12:0] hCount,
   output logic        lineStart,
   output logic        fieldStart,
   output logic        activeVideo,
   output logic        locked,
   output logic        lockLost
);

   localparam int unsigned LW              = 10;
   localparam int unsigned HW              = 13;
   localparam int unsigned CW              = 4;
   localparam int unsigned LINES_PER_FRAME = 625;

   typedef enum logic [1:0] {
      SEARCH   = 2'd0,
      VERIFY   = 2'd1,
      LOCKED   = 2'd2,
      HOLDOVER = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [LW-1:0]   line_d, line_inc, target, exp_plus2;
   logic [HW-1:0]   h_d;
   logic [CW-1:0]   good_q, good_d, miss_q, miss_d;
   logic            parity_q, parity_d;
   logic            vs_seen_q, vs_seen_d;
   logic            good_field, crossing, missed, timeout;
   logic            locked_d, line_start_d, field_start_d, lock_lost_d, active_d;

   // Line count after this cycle's hsync; vsync decisions use this value
   always_comb begin
      line_inc = lineNumber;
      if (hsync && lineNumber != '0)
         line_inc = (lineNumber == LW'(LINES_PER_FRAME)) ? LW'(1) : lineNumber + LW'(1);
   end

   // Field prediction; a missed vsync is declared when the count reaches target+2
   // and no vsync has been seen since the previous check point
   always_comb begin
      target     = isFieldOdd ? LW'(LINE_ODD) : LW'(LINE_EVEN);
      exp_plus2  = parity_q ? LW'(LINE_EVEN + 2) : LW'(LINE_ODD + 2);
      good_field = (line_inc == target) && (isFieldOdd != parity_q);
      crossing   = hsync && ((line_inc == LW'(LINE_ODD + 2)) || (line_inc == LW'(LINE_EVEN + 2)));
      missed     = crossing && !vsync && !vs_seen_q && (line_inc == exp_plus2);
      timeout    = (state_q != SEARCH) && (hCount == HW'(LINE_TIMEOUT));
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d       = state_q;
      line_d        = line_inc;
      parity_d      = parity_q;
      good_d        = good_q;
      miss_d        = miss_q;
      vs_seen_d     = vs_seen_q;
      field_start_d = 1'b0;
      lock_lost_d   = 1'b0;
      h_d           = hCount;

      if (hsync)
         h_d = '0;
      else if (hCount != HW'(LINE_TIMEOUT))
         h_d = hCount + HW'(1);

      if (vsync) begin
         vs_seen_d = 1'b1;
         parity_d  = isFieldOdd;
      end else if (crossing) begin
         vs_seen_d = 1'b0;
      end

      case (state_q)
         SEARCH: begin
            if (vsync) begin
               line_d  = target;
               good_d  = '0;
               state_d = VERIFY;
            end
         end
         VERIFY: begin
            if (vsync) begin
               if (good_field) begin
                  good_d = good_q + CW'(1);
                  if (good_q + CW'(1) == CW'(LOCK_FIELDS - 1)) begin
                     state_d = LOCKED;
                     miss_d  = '0;
                  end
               end else begin
                  line_d = target;
                  good_d = '0;
               end
            end
         end
         LOCKED: begin
            if (vsync && good_field) begin
               field_start_d = 1'b1;
            end else if (vsync || missed) begin
               // A missed field advances the parity prediction as if it had arrived
               if (!vsync)
                  parity_d = ~parity_q;
               state_d = HOLDOVER;
               miss_d  = CW'(1);
            end
         end
         HOLDOVER: begin
            if (vsync && good_field) begin
               state_d       = LOCKED;
               miss_d        = '0;
               field_start_d = 1'b1;
            end else if (vsync || missed) begin
               if (!vsync)
                  parity_d = ~parity_q;
               miss_d = miss_q + CW'(1);
               if (miss_q + CW'(1) >= CW'(MISS_LIMIT)) begin
                  state_d     = SEARCH;
                  line_d      = '0;
                  good_d      = '0;
                  miss_d      = '0;
                  lock_lost_d = 1'b1;
               end
            end
         end
         default: state_d = SEARCH;
      endcase

      // Loss of hsync overrides all field decisions
      if (timeout) begin
         state_d       = SEARCH;
         line_d        = '0;
         good_d        = '0;
         miss_d        = '0;
         field_start_d = 1'b0;
         lock_lost_d   = locked;
      end

      locked_d     = (state_d == LOCKED) || (state_d == HOLDOVER);
      line_start_d = hsync && locked_d;
      active_d     = locked_d &&
                     (h_d >= HW'(H_ACT_START)) && (h_d < HW'(H_ACT_END)) &&
                     (((line_d >= LW'(V_ACT1_FIRST)) && (line_d <= LW'(V_ACT1_LAST))) ||
                      ((line_d >= LW'(V_ACT2_FIRST)) && (line_d <= LW'(V_ACT2_LAST))));
   end

   // State and output registers
   always_ff @(posedge clk or negedge nReset) begin
      if (!nReset) begin
         state_q     <= SEARCH;
         lineNumber  <= '0;
         hCount      <= '0;
         parity_q    <= 1'b0;
         good_q      <= '0;
         miss_q      <= '0;
         vs_seen_q   <= 1'b0;
         lineStart   <= 1'b0;
         fieldStart  <= 1'b0;
         activeVideo <= 1'b0;
         locked      <= 1'b0;
         lockLost    <= 1'b0;
      end else begin
         state_q     <= state_d;
         lineNumber  <= line_d;
         hCount      <= h_d;
         parity_q    <= parity_d;
         good_q      <= good_d;
         miss_q      <= miss_d;
         vs_seen_q   <= vs_seen_d;
         lineStart   <= line_start_d;
         fieldStart  <= field_start_d;
         activeVideo <= active_d;
         locked      <= locked_d;
         lockLost    <= lock_lost_d;
      end
   end

endmodule

// File: tb/tb_pal_line_sequencer.sv
// Directed bench for pal_line_sequencer: lock acquisition, active window, glitch,
// persistent mismatch, coincident sync, async reset and hsync loss.
module tb_pal_line_sequencer;

   localparam int SHORT = 4;

   logic        clk = 1'b0;
   logic        n_reset = 1'b0;
   logic        hsync = 1'b0;
   logic        vsync = 1'b0;
   logic        is_odd = 1'b0;
   logic [9:0]  lineNumber;
   logic [12:0] hCount;
   logic        lineStart, fieldStart, activeVideo, locked, lockLost;

   pal_line_sequencer dut (
      .clk         (clk),
      .nReset      (n_reset),
      .hsync       (hsync),
      .vsync       (vsync),
      .isFieldOdd  (is_odd),
      .lineNumber  (lineNumber),
      .hCount      (hCount),
      .lineStart   (lineStart),
      .fieldStart  (fieldStart),
      .activeVideo (activeVideo),
      .locked      (locked),
      .lockLost    (lockLost)
   );

   always #6 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;
   int src      = 625;
   int ls_cnt, fs_cnt, ll_cnt, av_cnt, unl_cnt;
   int av_rise_h, av_rise_ln, av_fall_h;
   int vs_line, vs_locked;
   bit prev_av = 1'b0;

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic clr();
      ls_cnt = 0; fs_cnt = 0; ll_cnt = 0; av_cnt = 0; unl_cnt = 0;
      av_rise_h = -1; av_rise_ln = -1; av_fall_h = -1;
   endtask

   // One clock; outputs sampled 1 time unit after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (lineStart)  ls_cnt++;
      if (fieldStart) fs_cnt++;
      if (lockLost)   ll_cnt++;
      if (activeVideo) av_cnt++;
      if (!locked)    unl_cnt++;
      if (activeVideo && !prev_av) begin av_rise_h = int'(hCount); av_rise_ln = int'(lineNumber); end
      if (!activeVideo && prev_av) av_fall_h = int'(hCount);
      prev_av = activeVideo;
   endtask

   // One source line of len cycles, optionally carrying a vsync mid-line or coincident
   task automatic send(input int len, input bit vs, input bit odd, input bit coinc);
      int rem;
      hsync = 1'b1; vsync = vs && coinc; is_odd = odd;
      tick();
      if (vs && coinc) begin vs_locked = int'(locked); vs_line = int'(lineNumber); end
      hsync = 1'b0; vsync = 1'b0;
      rem = len - 1;
      if (vs && !coinc) begin
         vsync = 1'b1;
         tick();
         vsync = 1'b0;
         vs_locked = int'(locked); vs_line = int'(lineNumber);
         rem = len - 2;
      end
      repeat (rem) tick();
      src = (src == 625) ? 1 : src + 1;
   endtask

   // Short lines without vsync until the source has sent line stop
   task automatic goto_line(input int stop);
      for (int i = 0; i < 700 && src != stop; i++) send(SHORT, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic acquire(input bit coinc);
      src = 625;
      send(SHORT, 1'b1, 1'b1, coinc);
      goto_line(312); send(SHORT, 1'b1, 1'b0, coinc);
      goto_line(625); send(SHORT, 1'b1, 1'b1, coinc);
      goto_line(312); send(SHORT, 1'b1, 1'b0, coinc);
   endtask

   initial begin
      int k;
      clr();
      // Reset state
      repeat (3) tick();
      check("rst_line", int'(lineNumber), 0);
      check("rst_hcount", int'(hCount), 0);
      check("rst_locked", int'(locked), 0);
      n_reset = 1'b1;
      repeat (3) send(SHORT, 1'b0, 1'b0, 1'b0);
      check("search_line_zero", int'(lineNumber), 0);
      check("search_hsync_clears_hcount", int'(hCount), 3);
      check("search_no_linestart", ls_cnt, 0);

      // Lock acquisition: SEARCH load then 3 good fields
      src = 625;
      send(SHORT, 1'b1, 1'b1, 1'b0);
      check("load_odd_line", vs_line, 1);
      check("load_odd_locked", vs_locked, 0);
      goto_line(312); send(SHORT, 1'b1, 1'b0, 1'b0);
      check("f2_even_line", vs_line, 313);
      check("f2_locked", vs_locked, 0);
      goto_line(625); send(SHORT, 1'b1, 1'b1, 1'b0);
      check("f3_odd_line", vs_line, 1);
      check("f3_locked", vs_locked, 0);
      goto_line(312); send(SHORT, 1'b1, 1'b0, 1'b0);
      check("f4_locked", vs_locked, 1);
      clr();
      goto_line(320);
      check("locked_linestart", ls_cnt, 7);
      check("locked_line320", int'(lineNumber), 320);

      // Active window
      clr();
      goto_line(625); send(SHORT, 1'b1, 1'b1, 1'b0);
      check("good_odd_fieldstart", fs_cnt, 1);
      goto_line(21);
      clr(); send(1000, 1'b0, 1'b0, 1'b0);
      check("line22_inactive", av_cnt, 0);
      clr(); send(5184, 1'b0, 1'b0, 1'b0);
      check("line23_rise_h", av_rise_h, 851);
      check("line23_rise_line", av_rise_ln, 23);
      check("line23_fall_h", av_fall_h, 5063);
      check("line23_active_len", av_cnt, 5063 - 851);
      goto_line(310);
      clr(); send(1000, 1'b0, 1'b0, 1'b0);
      check("line311_inactive", av_cnt, 0);
      goto_line(312); send(SHORT, 1'b1, 1'b0, 1'b0);
      goto_line(623);
      clr(); send(1000, 1'b0, 1'b0, 1'b0);
      check("line624_inactive", av_cnt, 0);
      goto_line(625); send(SHORT, 1'b1, 1'b1, 1'b0);

      // Single dropped vsync
      clr();
      goto_line(312); send(SHORT, 1'b0, 1'b0, 1'b0);
      goto_line(400);
      check("glitch_flywheel_line", int'(lineNumber), 400);
      goto_line(625); send(SHORT, 1'b1, 1'b1, 1'b0);
      check("glitch_fieldstart", fs_cnt, 1);
      check("glitch_no_locklost", ll_cnt, 0);
      check("glitch_stayed_locked", unl_cnt, 0);
      check("glitch_line_after", vs_line, 1);

      // Two consecutive wrong-parity vsyncs
      clr();
      goto_line(312); send(SHORT, 1'b1, 1'b1, 1'b0);
      check("mis1_still_locked", vs_locked, 1);
      goto_line(625); send(SHORT, 1'b1, 1'b0, 1'b0);
      check("mis2_unlocked", vs_locked, 0);
      check("mis2_line_zero", vs_line, 0);
      check("mis2_locklost_once", ll_cnt, 1);

      // Reacquire with vsync coincident with hsync
      goto_line(312); send(SHORT, 1'b1, 1'b0, 1'b1);
      check("coinc_search_load", vs_line, 313);
      goto_line(625); send(SHORT, 1'b1, 1'b1, 1'b1);
      check("coinc_wrap_line", vs_line, 1);
      goto_line(312); send(SHORT, 1'b1, 1'b0, 1'b1);
      goto_line(625); send(SHORT, 1'b1, 1'b1, 1'b1);
      check("coinc_locked", vs_locked, 1);
      clr();
      goto_line(312); send(SHORT, 1'b1, 1'b0, 1'b1);
      check("coinc_312_313_fieldstart", fs_cnt, 1);
      check("coinc_312_313_line", vs_line, 313);
      check("coinc_no_locklost", ll_cnt, 0);

      // Asynchronous reset mid-frame
      goto_line(330);
      hsync = 1'b1; tick(); hsync = 1'b0;
      repeat (5) tick();
      n_reset = 1'b0;
      #1;
      check("async_rst_line", int'(lineNumber), 0);
      check("async_rst_hcount", int'(hCount), 0);
      check("async_rst_locked", int'(locked), 0);
      n_reset = 1'b1;
      repeat (3) send(SHORT, 1'b0, 1'b0, 1'b0);
      check("post_rst_line_zero", int'(lineNumber), 0);

      // Relock, then stop hsync
      acquire(1'b0);
      check("relock", vs_locked, 1);
      clr();
      hsync = 1'b1; tick(); hsync = 1'b0;
      k = 0;
      do begin tick(); k++; end while (!lockLost && k < 7000);
      check("timeout_cycles", k, 5601);
      check("timeout_unlocked", int'(locked), 0);
      check("timeout_line_zero", int'(lineNumber), 0);
      check("timeout_hcount_sat", int'(hCount), 5600);
      repeat (20) tick();
      check("timeout_locklost_once", ll_cnt, 1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/pal_line_sequencer.md
Name: pal_line_sequencer

Overview:
- Consumes the hsync, vsync and field-parity outputs of the PAL 576i sync regenerator and tracks the frame line number (1..625) and the horizontal position within the line.
- A lock state machine qualifies the incoming field sequence before it declares timing valid.
- It schedules per-line events (line start, field start, active-video window) for downstream overlay and capture logic.
- It runs in the same 81 MHz domain as the regenerator.

Parameters:
- LINE_ODD, 1: frame line loaded on an odd-field vsync.
- LINE_EVEN, 313: frame line loaded on an even-field vsync.
- LOCK_FIELDS, 4: number of consecutive good fields needed to lock.
- MISS_LIMIT, 2: number of consecutive bad fields tolerated in HOLDOVER.
- LINE_TIMEOUT, 5600: clk cycles without hsync that count as signal loss.
- H_ACT_START, 851: first active cycle after hsync (10.5 us).
- H_ACT_END, 5063: first inactive cycle after hsync (62.5 us).
- V_ACT1_FIRST/LAST, 23/310: active lines in field 1.
- V_ACT2_FIRST/LAST, 336/623: active lines in field 2.

Ports:
- clk  in  1  81 MHz clock.
- nReset  in  1  async active-low reset.
- hsync  in  1  single-cycle hsync pulse.
- vsync  in  1  single-cycle vsync-start pulse.
- isFieldOdd  in  1  field parity; valid in the vsync cycle.
- lineNumber  out  10  current frame line 1..625; 0 means unknown.
- hCount  out  13  cycles since last hsync; saturates at LINE_TIMEOUT.
- lineStart  out  1  one-cycle pulse per accepted hsync while locked.
- fieldStart  out  1  one-cycle pulse on a vsync that matches prediction while locked.
- activeVideo  out  1  high inside the active picture window while locked.
- locked  out  1  timing valid (state LOCKED or HOLDOVER).
- lockLost  out  1  one-cycle pulse on transition into SEARCH from LOCKED or HOLDOVER.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low on nReset. While nReset is low, every register and output is 0 and the state is SEARCH. Assertion mid-operation takes effect immediately. After release, the block restarts from SEARCH.
- Horizontal counter:
  - hCount is cleared on the cycle after hsync.
  - Otherwise it increments and saturates at LINE_TIMEOUT.
- Line counter:
  - Each hsync with lineNumber != 0 increments lineNumber; 625 wraps to 1.
  - If hsync and vsync arrive in the same cycle, the increment is applied first and the vsync load or compare then uses the incremented value.
- Prediction check on each vsync:
  - target = isFieldOdd ? LINE_ODD : LINE_EVEN.
  - The field is good when lineNumber == target and isFieldOdd differs from the parity seen at the previous vsync.
- States; all outputs are registered with 1-cycle latency from the input pulse:
  - SEARCH: on vsync, load lineNumber = target, store parity, set goodCnt = 0, go to VERIFY.
  - VERIFY:
    - On a good vsync, goodCnt++.
    - When goodCnt reaches LOCK_FIELDS-1, go to LOCKED on that vsync.
    - On a bad vsync, reload lineNumber = target and set goodCnt = 0; stay in VERIFY.
  - LOCKED:
    - On a good vsync, pulse fieldStart.
    - On a bad vsync, go to HOLDOVER with missCnt = 1. Keep the predicted lineNumber; do not reload.
    - If no vsync arrives by the line after the predicted one (lineNumber passes target+1 without a vsync), treat it as a bad field.
  - HOLDOVER:
    - locked stays 1 and outputs keep flywheeling on the predicted count.
    - On a good vsync, go to LOCKED with missCnt = 0 and pulse fieldStart.
    - On a bad field, missCnt++. When missCnt reaches MISS_LIMIT, go to SEARCH, pulse lockLost, and set lineNumber = 0.
- Timeout: hCount == LINE_TIMEOUT in any state except SEARCH forces SEARCH and sets lineNumber = 0. It pulses lockLost only if locked was 1.
- activeVideo = locked AND H_ACT_START <= hCount < H_ACT_END AND lineNumber is in [V_ACT1_FIRST, V_ACT1_LAST] or [V_ACT2_FIRST, V_ACT2_LAST]. Both boundaries are inclusive on lines and half-open on hCount.
- lineStart is asserted only while locked.
- hsync pulses arriving in SEARCH still clear hCount but produce no lineStart.

Test Plan:
- Reset behaviour: assert nReset low mid-frame -> all outputs read 0 asynchronously. Release -> state is SEARCH and lineNumber stays 0 until the first vsync.
- Lock acquisition: clean PAL stimulus (hsync every 5184 cycles, odd vsync then even vsync alternating, 312/313 lines apart) -> locked rises on the 4th field's vsync (3 good checks after the SEARCH load). lineNumber reads 313 at even vsync and 1 at odd vsync.
- Active window: while locked, on line 23 -> activeVideo rises at hCount 851 and falls at 5063. On lines 22, 311 and 624 it stays 0.
- Single glitch: drop one vsync while locked -> locked stays 1 and lineNumber keeps counting. The next good vsync gives a fieldStart pulse and no lockLost.
- Persistent mismatch: two consecutive wrong-parity vsyncs -> lockLost pulses once, locked = 0, lineNumber = 0.
- Signal loss and coincident pulses: stop hsync -> 5600 cycles later the block is in SEARCH with lockLost pulsed. Separately, hsync and vsync in the same cycle at the line-312 -> 313 boundary -> the field is judged good.
